// File: rtl/write_ctrl_gray.sv
// Write-domain controller for the asynchronous FIFO: write strobe/address,
// binary and Gray write pointers, read-pointer synchroniser and status flags.
module write_ctrl_gray #(
    parameter int depth        = 8,
    parameter int adr_width    = $clog2(depth),
    parameter int sync_stages  = 2,
    parameter int afull_thresh = depth - 2
) (
    input  logic                 clk_w,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic                 clr_ovf,
    input  logic [adr_width:0]   rd_ptr_gray,
    output logic                 write,
    output logic [adr_width-1:0] write_adr,
    output logic [adr_width:0]   wr_ptr_gray,
    output logic                 FIFO_full,
    output logic                 almost_full,
    output logic [adr_width:0]   fill_level,
    output logic                 overflow
);

    localparam int PW  = adr_width + 1;
    localparam int TOP = adr_width;

    function automatic logic [adr_width:0] bin2gray(input logic [adr_width:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [adr_width:0] gray2bin(input logic [adr_width:0] g);
        logic [adr_width:0] b;
        b[TOP] = g[TOP];
        for (int i = TOP - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [adr_width:0] wbin;
    logic [adr_width:0] wgray;
    logic [adr_width:0] rq_sync [sync_stages];
    logic [adr_width:0] rq;
    logic [adr_width:0] rbin_s;
    logic [adr_width:0] wbin_next;
    logic [adr_width:0] wgray_next;
    logic [adr_width:0] level_next;
    logic               full_next;

    // Read-pointer synchroniser: a Gray pointer changes one bit at a time, so
    // a plain flop chain gives either the old or the new value, never garbage.
    always_ff @(posedge clk_w) begin
        if (!reset) begin
            for (int i = 0; i < sync_stages; i++) begin
                rq_sync[i] <= '0;
            end
        end else begin
            rq_sync[0] <= rd_ptr_gray;
            for (int i = 1; i < sync_stages; i++) begin
                rq_sync[i] <= rq_sync[i-1];
            end
        end
    end

    assign rq     = rq_sync[sync_stages-1];
    assign rbin_s = gray2bin(rq);

    assign write      = wr_en && !FIFO_full;
    assign wbin_next  = wbin + PW'(write);
    assign wgray_next = bin2gray(wbin_next);

    // Full when the write pointer is exactly one lap ahead of the read pointer;
    // in Gray code that means the top two bits differ and the rest match.
    assign full_next  = (wgray_next == {~rq[TOP:TOP-1], rq[TOP-2:0]});
    assign level_next = wbin_next - rbin_s;

    // Pointer and status registers
    always_ff @(posedge clk_w) begin
        if (!reset) begin
            wbin        <= '0;
            wgray       <= '0;
            FIFO_full   <= 1'b0;
            almost_full <= 1'b0;
            fill_level  <= '0;
            overflow    <= 1'b0;
        end else begin
            wbin        <= wbin_next;
            wgray       <= wgray_next;
            FIFO_full   <= full_next;
            almost_full <= (level_next >= PW'(afull_thresh));
            fill_level  <= level_next;
            if (wr_en && FIFO_full) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    assign write_adr   = wbin[adr_width-1:0];
    assign wr_ptr_gray = wgray;

endmodule
